// File: rtl/lock_pkg.sv
// Shared lock definitions: readout states, digit width and default timing constants.
package lock_pkg;

  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned DWELL_DEF = 25_000_000;
  localparam int unsigned GAP_DEF   = 5_000_000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_e;

endpackage

// File: rtl/dwell_timer.sv
// Restartable up-counter with a single-cycle terminal-count strobe at a loadable last value.
module dwell_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic             restart,
  input  logic [CNT_W-1:0] last,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else if (restart) begin
      count_q <= '0;
    end else if (ce) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign tc = ce && (count_q == last);

endmodule

// File: rtl/nibble_readout.sv
// Serialises a stored password word onto the LED bank, MSB nibble first, one timed digit at a time.
module nibble_readout
  import lock_pkg::*;
#(
  parameter  int unsigned NIBBLES = 4,
  parameter  int unsigned DWELL   = DWELL_DEF,
  parameter  int unsigned GAP     = GAP_DEF,
  localparam int unsigned WORD_W  = NIBBLE_W * NIBBLES,
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                abort,
  input  logic [WORD_W-1:0]   data_i,
  output logic [NIBBLE_W-1:0] nibble_o,
  output logic                valid_o,
  output logic [IDX_W-1:0]    index_o,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CNT_MAX  = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shadow_q, shadow_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NIBBLE_W-1:0] nibble_q, nibble_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tc;
  logic                ce_c;
  logic                restart_c;
  logic [CNT_W-1:0]    last_c;
  logic [WORD_W-1:0]   shifted_c;

  // Counter runs only while a digit or gap is timing; any other cycle holds it at zero.
  assign ce_c      = (state_q == S_SHOW) || (state_q == S_GAP);
  assign restart_c = tc || abort || !ce_c;
  assign last_c    = (state_q == S_GAP) ? CNT_W'(GAP_LAST) : CNT_W'(DWELL - 1);
  assign shifted_c = shadow_q << NIBBLE_W;

  dwell_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .clr     (clr),
    .ce      (ce_c),
    .restart (restart_c),
    .last    (last_c),
    .tc      (tc)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      nibble_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      nibble_q <= nibble_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Outputs are computed for the state being entered, so they line up with it after the edge.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    nibble_d = '0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start && !abort) begin
          state_d  = S_SHOW;
          shadow_d = data_i;
          nibble_d = data_i[WORD_W-1 -: NIBBLE_W];
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      S_SHOW: begin
        busy_d   = 1'b1;
        valid_d  = 1'b1;
        nibble_d = shadow_q[WORD_W-1 -: NIBBLE_W];
        if (tc) begin
          if (idx_q == IDX_W'(NIBBLES - 1)) begin
            state_d  = S_DONE;
            valid_d  = 1'b0;
            nibble_d = '0;
            done_d   = 1'b1;
          end else if (GAP == 0) begin
            shadow_d = shifted_c;
            idx_d    = idx_q + IDX_W'(1);
            nibble_d = shifted_c[WORD_W-1 -: NIBBLE_W];
          end else begin
            state_d  = S_GAP;
            valid_d  = 1'b0;
            nibble_d = '0;
          end
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        if (tc) begin
          state_d  = S_SHOW;
          shadow_d = shifted_c;
          idx_d    = idx_q + IDX_W'(1);
          nibble_d = shifted_c[WORD_W-1 -: NIBBLE_W];
          valid_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    // Abort wins over everything and leaves no trace on the outputs.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      nibble_d = '0;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  assign nibble_o = nibble_q;
  assign valid_o  = valid_q;
  assign index_o  = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_nibble_readout.sv
// Bench for nibble_readout: per-cycle trace model built from the digit/gap timing rules, plus a GAP=0 instance.
module tb_nibble_readout;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned GP = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic        start, abort;
  logic [15:0] data_i;
  logic [3:0]  nibble_o;
  logic        valid_o;
  logic [1:0]  index_o;
  logic        busy, done;

  logic        start0, abort0;
  logic [15:0] data0;
  logic [3:0]  nibble0;
  logic        valid0;
  logic [1:0]  index0;
  logic        busy0, done0;

  always #5 clk = ~clk;

  nibble_readout #(.NIBBLES(N), .DWELL(DW), .GAP(GP)) dut (
    .clk(clk), .clr(clr), .start(start), .abort(abort), .data_i(data_i),
    .nibble_o(nibble_o), .valid_o(valid_o), .index_o(index_o), .busy(busy), .done(done)
  );

  nibble_readout #(.NIBBLES(N), .DWELL(DW), .GAP(0)) dut0 (
    .clk(clk), .clr(clr), .start(start0), .abort(abort0), .data_i(data0),
    .nibble_o(nibble0), .valid_o(valid0), .index_o(index0), .busy(busy0), .done(done0)
  );

  typedef struct packed {
    logic       valid;
    logic       busy;
    logic       done;
    logic [1:0] index;
    logic [3:0] nibble;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   dones  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected output for every cycle of one readout, straight from the digit/gap/done timing rules.
  function automatic void load(input logic [15:0] w);
    exp_t e;
    q.delete();
    for (int d = 0; d < int'(N); d++) begin
      for (int c = 0; c < int'(DW); c++) begin
        e = '{valid: 1'b1, busy: 1'b1, done: 1'b0, index: 2'(d), nibble: 4'(w >> (4 * (int'(N) - 1 - d)))};
        q.push_back(e);
      end
      if (d < int'(N) - 1) begin
        for (int c = 0; c < int'(GP); c++) begin
          e = '{valid: 1'b0, busy: 1'b1, done: 1'b0, index: 2'(d), nibble: 4'h0};
          q.push_back(e);
        end
      end
    end
    e = '{valid: 1'b0, busy: 1'b1, done: 1'b1, index: 2'(N - 1), nibble: 4'h0};
    q.push_back(e);
  endfunction

  // One clock: advance the model on the edge, compare all outputs on the falling edge.
  task automatic cyc(input string tag);
    @(posedge clk);
    if (cur.busy && abort) begin
      q.delete();
      cur = '0;
    end else if (!cur.busy && start && !abort) begin
      load(data_i);
      cur = q.pop_front();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = '0;
    end
    @(negedge clk);
    if (done) dones++;
    check(tag, 32'({valid_o, busy, done, index_o, nibble_o}), 32'(cur));
  endtask

  task automatic readout(input string tag, input logic [15:0] w, input int cycles);
    data_i = w;
    start  = 1'b1;
    cyc(tag);
    start  = 1'b0;
    repeat (cycles) cyc(tag);
  endtask

  initial begin
    int vcnt;
    int done_at;
    cur    = '0;
    clr    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    data_i = '0;
    start0 = 1'b0;
    abort0 = 1'b0;
    data0  = '0;
    #12;
    check("reset", 32'({valid_o, busy, done, index_o, nibble_o}), 32'h0);
    @(negedge clk);
    clr = 1'b0;

    // Basic readout and repeated-digit readout
    dones = 0;
    readout("t1_1a3f", 16'h1A3F, 26);
    check("t1_done_count", 32'(dones), 32'd1);
    readout("t2_7777", 16'h7777, 26);

    // Restart attempt while busy and data_i disturbed after acceptance
    dones  = 0;
    data_i = 16'h1A3F;
    start  = 1'b1;
    cyc("t3_isolate");
    for (int i = 1; i < 27; i++) begin
      start = (i == 4);
      if (i == 6) data_i = 16'h0000;
      cyc("t3_isolate");
    end
    start = 1'b0;
    check("t3_done_count", 32'(dones), 32'd1);

    // Abort during the second gap, then a clean readout
    dones = 0;
    readout("t4_pre", 16'h5A5A, 10);
    abort = 1'b1;
    cyc("t4_abort");
    abort = 1'b0;
    repeat (3) cyc("t4_idle");
    check("t4_no_done", 32'(dones), 32'd0);
    readout("t4_after", 16'h1A3F, 26);

    // Start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    cyc("t5_both");
    start = 1'b0;
    abort = 1'b0;
    repeat (2) cyc("t5_idle");

    // Asynchronous clear partway through a digit
    readout("t6_pre", 16'hC0DE, 2);
    @(posedge clk);
    #2 clr = 1'b1;
    #1 check("t6_clr_async", 32'({valid_o, busy, done, index_o, nibble_o}), 32'h0);
    q.delete();
    cur = '0;
    @(negedge clk);
    clr = 1'b0;
    readout("t6_c0de", 16'hC0DE, 26);

    // Randomised traffic: sporadic starts, rare aborts, noisy data
    for (int i = 0; i < 800; i++) begin
      start  = ($urandom_range(0, 7) == 0);
      abort  = ($urandom_range(0, 39) == 0);
      data_i = 16'($urandom);
      cyc("rand");
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (30) cyc("rand_tail");

    // GAP=0 instance: 16 contiguous valid cycles then done
    data0  = 16'hC0DE;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    data0  = 16'hFFFF;
    vcnt    = 0;
    done_at = -1;
    for (int i = 0; i < 20; i++) begin
      check("g0_valid", 32'(valid0), 32'(i < 16));
      if (valid0) begin
        check("g0_nibble", 32'(nibble0), 32'(4'(16'hC0DE >> (12 - 4 * (vcnt / 4)))));
        vcnt++;
      end
      if (done0 && done_at < 0) done_at = i;
      @(negedge clk);
    end
    check("g0_valid_count", 32'(vcnt), 32'd16);
    check("g0_done_at", 32'(done_at), 32'd16);
    check("g0_idle", 32'({valid0, busy0, done0, index0, nibble0}), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
